chunked_serial_adder: RTL and testbench

//  Parametrised multi-cycle ripple adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock.

---
 rtl/adder_pkg.sv | 15 +
 rtl/chunk_ripple_adder.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/chunked_serial_adder.sv | 103 ++++++++++
 tb/tb_chunked_serial_adder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM encoding and counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    full_adder u_fa (
      .x  (x[gi]),
      .y  (y[gi]),
      .ci (c[gi]),
      .s  (s[gi]),
      .co (c[gi+1])
    );
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: consumes CHUNK bits per clock, carry registered between chunks.
// Result is assembled LSB-chunk first by shifting chunk sums into sum_reg from the top.
module chunked_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co, chunk_cmsb;

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .x     (a_reg[CHUNK-1:0]),
    .y     (b_reg[CHUNK-1:0]),
    .ci    (carry_reg),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_cmsb)
  );

  // A single-chunk configuration has nothing to shift down; the chunk sum is the whole result.
  if (CHUNK == WIDTH) begin : g_sum_full
    assign sum_next = chunk_s;
  end else begin : g_sum_shift
    assign sum_next = {chunk_s, sum_reg[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | cin;
            cnt       <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> CHUNK;
          b_reg     <= b_reg >> CHUNK;
          sum_reg   <= sum_next;
          carry_reg <= chunk_co;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) begin
            cout_reg <= chunk_co;
            ovf_reg  <= chunk_co ^ chunk_cmsb;
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder: three instances (CHUNK = 4, 16, 1) share one clock,
// expected results come from plain integer arithmetic and are checked by a separate monitor.
module tb_chunked_serial_adder;

  localparam int ND = 3;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic        rst_i       [ND];
  logic        in_valid_i  [ND];
  logic        cin_i       [ND];
  logic        sub_i       [ND];
  logic        out_ready_i [ND];
  logic [15:0] a_i         [ND];
  logic [15:0] b_i         [ND];
  logic        in_ready_o  [ND];
  logic        out_valid_o [ND];
  logic [15:0] sum_o       [ND];
  logic        cout_o      [ND];
  logic        ovf_o       [ND];

  logic [17:0] exp_q [ND][$];
  int          acc_q [ND][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    chunked_serial_adder #(
      .WIDTH (16),
      .CHUNK ((gi == 0) ? 4 : (gi == 1) ? 16 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_i[gi]),
      .in_valid  (in_valid_i[gi]),
      .in_ready  (in_ready_o[gi]),
      .a         (a_i[gi]),
      .b         (b_i[gi]),
      .cin       (cin_i[gi]),
      .sub       (sub_i[gi]),
      .out_valid (out_valid_o[gi]),
      .out_ready (out_ready_i[gi]),
      .sum       (sum_o[gi]),
      .cout      (cout_o[gi]),
      .ovf       (ovf_o[gi])
    );
  end

  function automatic int nch(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 16;
  endfunction

  // Reference: unsigned and signed arithmetic on whole operands; returns {sum, cout, ovf}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    int sa, sb, r;
    logic [16:0] full;
    logic c;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = {1'b0, a} - {1'b0, b};
      c    = (a >= b);
      r    = sa - sb;
    end else begin
      full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      c    = full[16];
      r    = sa + sb + int'(ci);
    end
    return {full[15:0], c, (r > 32767) || (r < -32768)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset(input int d, input string tag);
    chk($sformatf("%s_dut%0d_out_valid", tag, d), 32'(out_valid_o[d]), 32'd0);
    chk($sformatf("%s_dut%0d_sum", tag, d), 32'(sum_o[d]), 32'd0);
    chk($sformatf("%s_dut%0d_cout", tag, d), 32'(cout_o[d]), 32'd0);
    chk($sformatf("%s_dut%0d_ovf", tag, d), 32'(ovf_o[d]), 32'd0);
    chk($sformatf("%s_dut%0d_in_ready", tag, d), 32'(in_ready_o[d]), 32'd1);
  endtask

  // Waits for in_ready, presents one operation for one accepting edge, then scrambles operands.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic s);
    int waited = 0;
    @(negedge clk);
    while (!in_ready_o[d] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout dut%0d: in_ready got 0, expected 1", d);
      return;
    end
    a_i[d] = a; b_i[d] = b; cin_i[d] = ci; sub_i[d] = s;
    in_valid_i[d] = 1'b1;
    @(posedge clk); #1;
    acc_q[d].push_back(cyc);
    exp_q[d].push_back(model(a, b, ci, s));
    @(negedge clk);
    in_valid_i[d] = 1'b0;
    a_i[d] = 16'($urandom); b_i[d] = 16'($urandom);
    cin_i[d] = 1'($urandom); sub_i[d] = 1'($urandom);
  endtask

  task automatic drain(input int d);
    int k = 0;
    while ((exp_q[d].size() != 0 || !in_ready_o[d]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("drain_dut%0d_pending", d), 32'(exp_q[d].size()), 32'd0);
  endtask

  // Monitor: compare every new result against the head of the scoreboard.
  initial begin
    logic        prev [ND];
    logic [17:0] e;
    int          t;
    for (int d = 0; d < ND; d++) prev[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!rst_i[d] && out_valid_o[d] && !prev[d]) begin
          if (exp_q[d].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result dut%0d: got sum %h, expected no result", d, sum_o[d]);
          end else begin
            e = exp_q[d].pop_front();
            t = acc_q[d].pop_front();
            $display("dut%0d chunk_cycles=%0d sum=%h cout=%b ovf=%b exp=%h/%b/%b latency=%0d",
                     d, nch(d), sum_o[d], cout_o[d], ovf_o[d], e[17:2], e[1], e[0], cyc - t);
            chk($sformatf("dut%0d_result", d), {14'd0, sum_o[d], cout_o[d], ovf_o[d]}, {14'd0, e});
            chk($sformatf("dut%0d_latency", d), 32'(cyc - t), 32'(nch(d)));
          end
        end
        prev[d] = out_valid_o[d] && !rst_i[d];
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int k;
    for (int d = 0; d < ND; d++) begin
      rst_i[d] = 1'b1; in_valid_i[d] = 1'b0; cin_i[d] = 1'b0; sub_i[d] = 1'b0;
      out_ready_i[d] = 1'b1; a_i[d] = '0; b_i[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) check_reset(d, "por");
    for (int d = 0; d < ND; d++) rst_i[d] = 1'b0;

    // Directed vectors on every configuration.
    for (int d = 0; d < ND; d++) begin
      issue(d, 16'h1234, 16'h4321, 1'b1, 1'b0);
      issue(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      issue(d, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      issue(d, 16'h0005, 16'h0007, 1'b1, 1'b1);
      issue(d, 16'h8000, 16'h0001, 1'b0, 1'b1);
      drain(d);
    end

    // Backpressure on the CHUNK=4 instance, with a second op waiting on in_valid.
    out_ready_i[0] = 1'b0;
    issue(0, 16'hABCD, 16'h1111, 1'b0, 1'b0);
    a_i[0] = 16'h0F0F; b_i[0] = 16'h0101; cin_i[0] = 1'b1; sub_i[0] = 1'b0;
    in_valid_i[0] = 1'b1;
    k = 0;
    while (!out_valid_o[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid_seen", 32'(out_valid_o[0]), 32'd1);
    held = sum_o[0];
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid_held", 32'(out_valid_o[0]), 32'd1);
      chk("bp_sum_held", 32'(sum_o[0]), 32'(held));
      chk("bp_in_ready_low", 32'(in_ready_o[0]), 32'd0);
    end
    out_ready_i[0] = 1'b1;
    @(negedge clk);
    chk("bp_back_to_idle", 32'(in_ready_o[0]), 32'd1);
    chk("bp_out_valid_drop", 32'(out_valid_o[0]), 32'd0);
    @(posedge clk); #1;
    acc_q[0].push_back(cyc);
    exp_q[0].push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
    @(negedge clk);
    chk("bp_next_accepted", 32'(in_ready_o[0]), 32'd0);
    in_valid_i[0] = 1'b0;
    drain(0);

    // Reset two cycles into RUN discards the op; the next op computes normally.
    issue(0, 16'h1234, 16'h4321, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_i[0] = 1'b1;
    #1;
    check_reset(0, "midrun");
    void'(exp_q[0].pop_back());
    void'(acc_q[0].pop_back());
    @(negedge clk);
    rst_i[0] = 1'b0;
    @(negedge clk);
    check_reset(0, "post_rst");
    issue(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    drain(0);

    // Randomised traffic, with corner operands mixed in.
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 25; i++) begin
        logic [15:0] ra, rb;
        ra = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
        rb = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
        issue(d, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
